// File: rtl/serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator
//   WIDTH-bit magnitude comparator evaluated one bit per clock, MSB first.
//   Supports unsigned and two's-complement operands. With EARLY_EXIT=1 the scan
//   stops at the first differing bit; with EARLY_EXIT=0 it always scans all
//   WIDTH bits and the first recorded difference wins.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   signed_mode  1: operands are two's complement (sampled with start)
//   a, b         WIDTH-bit operands (sampled with start)
//   busy         high while a comparison is running
//   done         one-cycle pulse; results valid from this cycle
//   greater      A > B
//   lesser       A < B
//   equal        A == B
//   Results hold until the next start is accepted. All outputs are registered.
// -----------------------------------------------------------------------------
module serial_mag_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    localparam int                 IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]   IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               signed_q, signed_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               greater_q, greater_d;
    logic               lesser_q, lesser_d;
    logic               equal_q, equal_d;

    // Per-bit compare cell
    logic bit_a, bit_b;
    logic a_hi, b_hi;
    logic invert;
    logic diff_seen;

    always_comb begin
        bit_a     = a_q[idx_q];
        bit_b     = b_q[idx_q];
        a_hi      = bit_a & ~bit_b;
        b_hi      = ~bit_a & bit_b;
        // The sign bit carries negative weight, so its sense flips.
        invert    = signed_q && (idx_q == IDX_MSB);
        diff_seen = greater_q | lesser_q;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        idx_d     = idx_q;
        greater_d = greater_q;
        lesser_d  = lesser_q;
        equal_d   = equal_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    signed_d  = signed_mode;
                    idx_d     = IDX_MSB;
                    greater_d = 1'b0;
                    lesser_d  = 1'b0;
                    equal_d   = 1'b0;
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                // Only the first (most significant) difference is recorded.
                if ((bit_a != bit_b) && !diff_seen) begin
                    greater_d = invert ? b_hi : a_hi;
                    lesser_d  = invert ? a_hi : b_hi;
                    if (EARLY_EXIT) begin
                        state_d = S_DONE;
                    end
                end

                if (idx_q == '0) begin
                    state_d = S_DONE;
                    if (!diff_seen && (bit_a == bit_b)) begin
                        equal_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            idx_q     <= '0;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            idx_q     <= idx_d;
            greater_q <= greater_d;
            lesser_q  <= lesser_d;
            equal_q   <= equal_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign greater = greater_q;
    assign lesser  = lesser_q;
    assign equal   = equal_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comparator
//   Five instances share operand inputs, each with its own start:
//     0: WIDTH=8 EARLY_EXIT=1   1: WIDTH=8 EARLY_EXIT=0
//     2: WIDTH=4 EARLY_EXIT=1   3: WIDTH=4 EARLY_EXIT=0
//     4: WIDTH=1 EARLY_EXIT=1
//   Directed vectors with hand-computed results, hand-written corner sequences,
//   and an exhaustive WIDTH=4 sweep against a $signed/unsigned model.
// -----------------------------------------------------------------------------
module tb_serial_mag_comparator;

    logic       clk;
    logic       rst_n;
    logic [4:0] start_v;
    logic       sm_i;
    logic [7:0] a8;
    logic [7:0] b8;

    wire  [4:0] busy_v, done_v, g_v, l_v, e_v;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8_ee (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm_i),
        .a(a8), .b(b8), .busy(busy_v[0]), .done(done_v[0]),
        .greater(g_v[0]), .lesser(l_v[0]), .equal(e_v[0]));

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8_full (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm_i),
        .a(a8), .b(b8), .busy(busy_v[1]), .done(done_v[1]),
        .greater(g_v[1]), .lesser(l_v[1]), .equal(e_v[1]));

    serial_mag_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) u_w4_ee (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm_i),
        .a(a8[3:0]), .b(b8[3:0]), .busy(busy_v[2]), .done(done_v[2]),
        .greater(g_v[2]), .lesser(l_v[2]), .equal(e_v[2]));

    serial_mag_comparator #(.WIDTH(4), .EARLY_EXIT(1'b0)) u_w4_full (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .signed_mode(sm_i),
        .a(a8[3:0]), .b(b8[3:0]), .busy(busy_v[3]), .done(done_v[3]),
        .greater(g_v[3]), .lesser(l_v[3]), .equal(e_v[3]));

    serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1_ee (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .signed_mode(sm_i),
        .a(a8[0:0]), .b(b8[0:0]), .busy(busy_v[4]), .done(done_v[4]),
        .greater(g_v[4]), .lesser(l_v[4]), .equal(e_v[4]));

    typedef struct {
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [2:0] res;   // {greater, lesser, equal}
        int         lat;   // cycles from start edge to DONE edge
    } vec_t;

    localparam int N_VEC = 15;
    vec_t vecs[N_VEC];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Run one comparison on instance k and check result, latency, busy
    // duration, the single-cycle done pulse and result hold afterwards.
    task automatic do_vec(input string tag, input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic sm,
                          input logic [2:0] exp_res, input int exp_lat);
        int cycles;
        int busy_n;
        @(negedge clk);
        a8 = a;
        b8 = b;
        sm_i = sm;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        cycles = 0;
        busy_n = 0;
        while (!done_v[k] && cycles < 40) begin
            if (busy_v[k]) busy_n++;
            @(negedge clk);
            cycles++;
        end
        check({tag, " result"}, {29'd0, g_v[k], l_v[k], e_v[k]}, {29'd0, exp_res});
        check({tag, " latency"}, cycles, exp_lat);
        check({tag, " busy cycles"}, busy_n, exp_lat);
        check({tag, " busy in done"}, {31'd0, busy_v[k]}, 32'd0);
        @(negedge clk);
        check({tag, " done pulse width"}, {31'd0, done_v[k]}, 32'd0);
        check({tag, " result hold"}, {29'd0, g_v[k], l_v[k], e_v[k]}, {29'd0, exp_res});
    endtask

    initial begin
        vecs[0]  = '{0, 8'hA5, 8'h5A, 1'b0, 3'b100, 1};
        vecs[1]  = '{0, 8'h3C, 8'h3C, 1'b0, 3'b001, 8};
        vecs[2]  = '{0, 8'h80, 8'h01, 1'b1, 3'b010, 1};
        vecs[3]  = '{0, 8'h80, 8'h01, 1'b0, 3'b100, 1};
        vecs[4]  = '{0, 8'h7F, 8'h80, 1'b1, 3'b100, 1};
        vecs[5]  = '{0, 8'hFF, 8'hFE, 1'b1, 3'b100, 8};
        vecs[6]  = '{0, 8'h01, 8'h02, 1'b0, 3'b010, 7};
        vecs[7]  = '{0, 8'hFE, 8'hFF, 1'b1, 3'b010, 8};
        vecs[8]  = '{1, 8'h80, 8'h00, 1'b0, 3'b100, 8};
        vecs[9]  = '{1, 8'h01, 8'h00, 1'b0, 3'b100, 8};
        vecs[10] = '{1, 8'hF0, 8'h0F, 1'b0, 3'b100, 8};
        vecs[11] = '{1, 8'hF0, 8'h0F, 1'b1, 3'b010, 8};
        vecs[12] = '{4, 8'h01, 8'h00, 1'b1, 3'b010, 1};
        vecs[13] = '{4, 8'h01, 8'h00, 1'b0, 3'b100, 1};
        vecs[14] = '{4, 8'h01, 8'h01, 1'b1, 3'b001, 1};

        rst_n   = 1'b0;
        start_v = '0;
        sm_i    = 1'b0;
        a8      = '0;
        b8      = '0;

        // Reset state across all instances
        #12;
        check("reset outputs", {7'd0, busy_v, done_v, g_v, l_v, e_v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < N_VEC; i++) begin
            do_vec($sformatf("vec%0d", i), vecs[i].k, vecs[i].a, vecs[i].b,
                   vecs[i].sm, vecs[i].res, vecs[i].lat);
        end

        // Inputs churn during RUN and DONE: result follows the latched operands
        begin
            int cyc;
            @(negedge clk);
            a8 = 8'h3C;
            b8 = 8'h3C;
            sm_i = 1'b0;
            start_v[0] = 1'b1;
            @(negedge clk);
            cyc = 0;
            while (!done_v[0] && cyc < 40) begin
                start_v[0] = 1'b1;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                sm_i = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
            check("churn latency", cyc, 8);
            check("churn result", {29'd0, g_v[0], l_v[0], e_v[0]}, 32'b001);
            // start still high through the DONE cycle: must be ignored
            a8 = 8'hFF;
            b8 = 8'h00;
            @(negedge clk);
            start_v[0] = 1'b0;
            check("churn idle after done", {30'd0, busy_v[0], done_v[0]}, 32'd0);
            check("churn result hold", {29'd0, g_v[0], l_v[0], e_v[0]}, 32'b001);
            @(negedge clk);
            check("no second op", {30'd0, busy_v[0], done_v[0]}, 32'd0);
        end

        // Reset mid-RUN on the full-scan instance after a difference is recorded
        begin
            logic seen_done;
            @(negedge clk);
            a8 = 8'h80;
            b8 = 8'h00;
            sm_i = 1'b0;
            start_v[1] = 1'b1;
            @(negedge clk);
            start_v[1] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("midrun recorded greater", {30'd0, busy_v[1], g_v[1]}, 32'b11);
            rst_n = 1'b0;
            #1;
            check("midrun reset outputs", {7'd0, busy_v, done_v, g_v, l_v, e_v}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            seen_done = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done_v[1] || busy_v[1]) seen_done = 1'b1;
            end
            check("no done after reset", {31'd0, seen_done}, 32'd0);
            do_vec("post reset", 1, 8'h80, 8'h00, 1'b0, 3'b100, 8);
        end

        // Exhaustive WIDTH=4 sweep, both modes, both EARLY_EXIT settings
        for (int ee = 0; ee < 2; ee++) begin
            for (int s = 0; s < 2; s++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        logic [3:0] xa, yb;
                        logic [2:0] exp_res;
                        int         fd;
                        bit         found;
                        xa = 4'(x);
                        yb = 4'(y);
                        if (s == 1) begin
                            if ($signed(xa) > $signed(yb))      exp_res = 3'b100;
                            else if ($signed(xa) < $signed(yb)) exp_res = 3'b010;
                            else                                exp_res = 3'b001;
                        end else begin
                            if (xa > yb)      exp_res = 3'b100;
                            else if (xa < yb) exp_res = 3'b010;
                            else              exp_res = 3'b001;
                        end
                        fd = 0;
                        found = 1'b0;
                        for (int j = 3; j >= 0; j--) begin
                            if (!found && (xa[j] != yb[j])) begin
                                fd = j;
                                found = 1'b1;
                            end
                        end
                        do_vec($sformatf("w4 ee%0d s%0d a%h b%h", ee, s, xa, yb),
                               (ee == 1) ? 2 : 3, {4'd0, xa}, {4'd0, yb}, s[0],
                               exp_res, (ee == 1) ? (4 - fd) : 4);
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
